// File: rtl/lc3b_mem_responder_if.sv
// LC-3b memory port: the initiator holds a request until the responder pulses mem_resp.
interface lc3b_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_wmask;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        mem_err;

    modport master (
        output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
        input  mem_rdata, mem_resp, mem_err
    );

    modport slave (
        input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
        output mem_rdata, mem_resp, mem_err
    );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Word-array memory responder: captures a request in IDLE, answers with a one-cycle mem_resp LATENCY cycles later.
// No backpressure beyond the hold-until-resp protocol; one transaction in flight, one per LATENCY+1 cycles.
module lc3b_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    lc3b_mem_responder_if.slave  bus
);
    localparam int IDXW = $clog2(DEPTH_WORDS);
    localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            rd_q;
    logic            wr_q;
    logic [1:0]      wmask_q;
    logic [14:0]     waddr_q;
    logic [15:0]     wdata_q;
    logic            resp_q;
    logic            err_q;
    logic [15:0]     rdata_q;

    logic [15:0]     mem_array [DEPTH_WORDS];

    logic            req;
    logic            op_rd;
    logic            op_wr;
    logic [1:0]      op_mask;
    logic [14:0]     op_waddr;
    logic [15:0]     op_wdata;
    logic            commit;
    logic            in_range;
    logic            proto_err;
    logic            op_err;
    logic            do_write;
    logic [IDXW-1:0] idx;
    logic [15:0]     rd_word;
    logic            unused_addr_b0;

    assign req            = bus.mem_read | bus.mem_write;
    assign unused_addr_b0 = bus.mem_address[0];

    // With LATENCY=1 the commit edge is the capture edge, so the live inputs are the operands.
    always_comb begin
        op_rd    = rd_q;
        op_wr    = wr_q;
        op_mask  = wmask_q;
        op_waddr = waddr_q;
        op_wdata = wdata_q;
        if (state_q == IDLE) begin
            op_rd    = bus.mem_read;
            op_wr    = bus.mem_write;
            op_mask  = bus.mem_wmask;
            op_waddr = bus.mem_address[15:1];
            op_wdata = bus.mem_wdata;
        end
    end

    assign commit    = reset_n &&
                       (((state_q == IDLE) && req && (LATENCY == 1)) ||
                        ((state_q == WAIT) && (cnt_q == CW'(1))));
    assign in_range  = {2'b00, op_waddr} < 17'(DEPTH_WORDS);
    assign proto_err = op_rd & op_wr;
    assign op_err    = proto_err | ~in_range;
    assign do_write  = commit & op_wr & ~op_err;
    assign idx       = op_waddr[IDXW-1:0];
    assign rd_word   = mem_array[idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wmask_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            resp_q <= commit;
            err_q  <= commit & op_err;
            if (commit) begin
                if (proto_err) begin
                    rdata_q <= '0;
                end else if (op_rd) begin
                    rdata_q <= in_range ? rd_word : 16'h0000;
                end
            end
            case (state_q)
                IDLE: begin
                    if (req) begin
                        rd_q    <= bus.mem_read;
                        wr_q    <= bus.mem_write;
                        wmask_q <= bus.mem_wmask;
                        waddr_q <= bus.mem_address[15:1];
                        wdata_q <= bus.mem_wdata;
                        cnt_q   <= CW'(LATENCY - 1);
                        state_q <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    // Counter reaching zero marks the commit edge.
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Array contents survive reset; reset only blocks a commit.
    always_ff @(posedge clk) begin
        if (do_write) begin
            if (op_mask[0]) mem_array[idx][7:0]  <= op_wdata[7:0];
            if (op_mask[1]) mem_array[idx][15:8] <= op_wdata[15:8];
        end
    end

    assign bus.mem_resp  = resp_q;
    assign bus.mem_err   = err_q;
    assign bus.mem_rdata = rdata_q;
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: a LATENCY=3 and a LATENCY=1 instance checked against a timestamp-based memory model.
module tb_lc3b_mem_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    lc3b_mem_responder_if b3();
    lc3b_mem_responder_if b1();

    lc3b_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(b3)
    );
    lc3b_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each request is a timestamped event; its result is computed from the rules at its commit edge.
    int          lat_of [2] = '{3, 1};
    logic [15:0] mm [2][256];
    bit          pend [2]   = '{0, 0};
    int          cap_e [2]  = '{0, 0};
    int          free_e [2] = '{0, 0};
    bit          m_rd [2];
    bit          m_wr [2];
    logic [1:0]  m_mask [2];
    logic [15:0] m_addr [2];
    logic [15:0] m_wdata [2];
    bit          exp_resp [2]  = '{0, 0};
    bit          exp_err [2]   = '{0, 0};
    logic [15:0] exp_rdata [2] = '{16'h0000, 16'h0000};
    int          e = 0;

    bit          s_rd, s_wr, oor, pe;
    logic [1:0]  s_mk;
    logic [15:0] s_ad, s_wd;
    int          w;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < 2; d++) begin
                pend[d]      = 1'b0;
                free_e[d]    = 0;
                exp_resp[d]  = 1'b0;
                exp_err[d]   = 1'b0;
                exp_rdata[d] = 16'h0000;
            end
        end else begin
            e++;
            for (int d = 0; d < 2; d++) begin
                s_rd = (d == 0) ? b3.mem_read    : b1.mem_read;
                s_wr = (d == 0) ? b3.mem_write   : b1.mem_write;
                s_mk = (d == 0) ? b3.mem_wmask   : b1.mem_wmask;
                s_ad = (d == 0) ? b3.mem_address : b1.mem_address;
                s_wd = (d == 0) ? b3.mem_wdata   : b1.mem_wdata;
                exp_resp[d] = 1'b0;
                exp_err[d]  = 1'b0;
                if (!pend[d] && e >= free_e[d] && (s_rd || s_wr)) begin
                    pend[d]    = 1'b1;
                    cap_e[d]   = e;
                    m_rd[d]    = s_rd;
                    m_wr[d]    = s_wr;
                    m_mask[d]  = s_mk;
                    m_addr[d]  = s_ad;
                    m_wdata[d] = s_wd;
                end
                if (pend[d] && e == cap_e[d] + lat_of[d] - 1) begin
                    w   = int'(m_addr[d]) / 2;
                    oor = (w >= 256);
                    pe  = m_rd[d] && m_wr[d];
                    exp_resp[d] = 1'b1;
                    exp_err[d]  = oor || pe;
                    if (pe) begin
                        exp_rdata[d] = 16'h0000;
                    end else if (m_rd[d]) begin
                        exp_rdata[d] = oor ? 16'h0000 : mm[d][w];
                    end else if (!oor) begin
                        if (m_mask[d][0]) mm[d][w][7:0]  = m_wdata[d][7:0];
                        if (m_mask[d][1]) mm[d][w][15:8] = m_wdata[d][15:8];
                    end
                    pend[d]   = 1'b0;
                    free_e[d] = e + 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("d3 mem_resp",  16'(b3.mem_resp), 16'(exp_resp[0]));
        check("d3 mem_err",   16'(b3.mem_err),  16'(exp_err[0]));
        check("d3 mem_rdata", b3.mem_rdata,     exp_rdata[0]);
        check("d1 mem_resp",  16'(b1.mem_resp), 16'(exp_resp[1]));
        check("d1 mem_err",   16'(b1.mem_err),  16'(exp_err[1]));
        check("d1 mem_rdata", b1.mem_rdata,     exp_rdata[1]);
    end

    task automatic drive(input int d, input bit rd, input bit wr, input logic [1:0] mk,
                         input logic [15:0] ad, input logic [15:0] wd);
        if (d == 0) begin
            b3.mem_read = rd; b3.mem_write = wr; b3.mem_wmask = mk;
            b3.mem_address = ad; b3.mem_wdata = wd;
        end else begin
            b1.mem_read = rd; b1.mem_write = wr; b1.mem_wmask = mk;
            b1.mem_address = ad; b1.mem_wdata = wd;
        end
    endtask

    // Called just after a negedge; the request is sampled at the end of that cycle (cycle 0).
    task automatic txn(input int d, input bit rd, input bit wr, input logic [1:0] mk,
                       input logic [15:0] ad, input logic [15:0] wd,
                       input bit sw, input logic [15:0] sw_ad,
                       output logic [15:0] rdata, output bit err, output int lat);
        lat   = -1;
        rdata = 16'h0000;
        err   = 1'b0;
        drive(d, rd, wr, mk, ad, wd);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if ((d == 0) ? b3.mem_resp : b1.mem_resp) begin
                lat   = k;
                rdata = (d == 0) ? b3.mem_rdata : b1.mem_rdata;
                err   = (d == 0) ? b3.mem_err : b1.mem_err;
                break;
            end
            if (sw && k == 1) drive(d, rd, wr, mk, sw_ad, wd);
        end
        drive(d, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        if (lat < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: no mem_resp within 20 cycles on dut %0d", d);
        end
        @(negedge clk);
    endtask

    task automatic op(input string nm, input int d, input bit rd, input bit wr,
                      input logic [1:0] mk, input logic [15:0] ad, input logic [15:0] wd,
                      input bit chk_rd, input logic [15:0] xr, input bit xe);
        logic [15:0] r;
        bit          er;
        int          lt;
        txn(d, rd, wr, mk, ad, wd, 1'b0, 16'h0000, r, er, lt);
        check({nm, " latency"}, 16'(lt), 16'(lat_of[d]));
        check({nm, " err"}, 16'(er), 16'(xe));
        if (chk_rd) check({nm, " rdata"}, r, xr);
    endtask

    initial begin
        logic [15:0] r;
        bit          er;
        int          lt;
        int          p1, p2, np;

        drive(0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        drive(1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset resp", 16'(b3.mem_resp), 16'h0000);
        check("reset err", 16'(b3.mem_err), 16'h0000);
        check("reset rdata", b1.mem_rdata, 16'h0000);
        #2 reset_n = 1'b1;
        @(negedge clk);

        op("w10 beef",   0, 0, 1, 2'b11, 16'h0010, 16'hBEEF, 0, 16'h0000, 0);
        op("r10",        0, 1, 0, 2'b00, 16'h0010, 16'h0000, 1, 16'hBEEF, 0);
        op("w20 1234",   0, 0, 1, 2'b11, 16'h0020, 16'h1234, 0, 16'h0000, 0);
        op("w20 lo",     0, 0, 1, 2'b01, 16'h0020, 16'hAB55, 0, 16'h0000, 0);
        op("w20 hi",     0, 0, 1, 2'b10, 16'h0020, 16'hCD00, 0, 16'h0000, 0);
        op("r20 bytes",  0, 1, 0, 2'b11, 16'h0020, 16'h0000, 1, 16'hCD55, 0);
        op("w20 nomask", 0, 0, 1, 2'b00, 16'h0020, 16'hFFFF, 0, 16'h0000, 0);
        op("r20 nomask", 0, 1, 0, 2'b00, 16'h0020, 16'h0000, 1, 16'hCD55, 0);
        op("w31 odd",    0, 0, 1, 2'b11, 16'h0031, 16'h5A5A, 0, 16'h0000, 0);
        op("r30 even",   0, 1, 0, 2'b00, 16'h0030, 16'h0000, 1, 16'h5A5A, 0);
        op("w idx0",     0, 0, 1, 2'b11, 16'h0000, 16'h0A0A, 0, 16'h0000, 0);
        op("w idx255",   0, 0, 1, 2'b11, 16'h01FE, 16'hF0F0, 0, 16'h0000, 0);
        op("r oor",      0, 1, 0, 2'b00, 16'h0200, 16'h0000, 1, 16'h0000, 1);
        op("w oor",      0, 0, 1, 2'b11, 16'h0200, 16'hDEAD, 1, 16'h0000, 1);
        op("r idx0",     0, 1, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0A0A, 0);
        op("r idx255",   0, 1, 0, 2'b00, 16'h01FE, 16'h0000, 1, 16'hF0F0, 0);
        op("rw proto",   0, 1, 1, 2'b11, 16'h0010, 16'h0000, 1, 16'h0000, 1);
        op("r10 intact", 0, 1, 0, 2'b00, 16'h0010, 16'h0000, 1, 16'hBEEF, 0);

        txn(0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 1'b1, 16'h0020, r, er, lt);
        check("addr switch rdata", r, 16'hBEEF);
        check("addr switch latency", 16'(lt), 16'd3);

        // Held read: second capture in cycle 4, so pulses in cycles 3 and 7.
        p1 = -1; p2 = -1; np = 0;
        drive(0, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (b3.mem_resp) begin
                np++;
                if (p1 < 0) p1 = k; else p2 = k;
            end
        end
        drive(0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        check("held first pulse", 16'(p1), 16'd3);
        check("held second pulse", 16'(p2), 16'd7);
        check("held pulse count", 16'(np), 16'd2);
        repeat (3) @(negedge clk);

        op("w40 1111", 0, 0, 1, 2'b11, 16'h0040, 16'h1111, 0, 16'h0000, 0);
        drive(0, 1'b0, 1'b1, 2'b11, 16'h0040, 16'h2222);
        @(negedge clk);
        #2 reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        np = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (b3.mem_resp) np++;
        end
        check("abort no resp", 16'(np), 16'd0);
        check("abort rdata", b3.mem_rdata, 16'h0000);
        check("abort err", 16'(b3.mem_err), 16'h0000);
        #2 reset_n = 1'b1;
        @(negedge clk);
        op("r40 retained", 0, 1, 0, 2'b00, 16'h0040, 16'h0000, 1, 16'h1111, 0);

        op("l1 w08", 1, 0, 1, 2'b11, 16'h0008, 16'h7777, 0, 16'h0000, 0);
        op("l1 r08", 1, 1, 0, 2'b00, 16'h0008, 16'h0000, 1, 16'h7777, 0);
        op("l1 r oor", 1, 1, 0, 2'b00, 16'hFFFE, 16'h0000, 1, 16'h0000, 1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/lc3b_mem_responder.md
Name: lc3b_mem_responder

Overview:
- Memory-side responder for the LC-3b pipeline memory port.
- Accepts the mem_read/mem_write/mem_wmask requests that the pipeline's fetch and MEM stages issue, and serves them from an internal word array after a programmable latency.
- Completes each transaction with a one-cycle mem_resp.
- Used as the behavioural memory behind the datapath and as the bench-side model for pipeline stall and forwarding tests.

Parameters:
- DEPTH_WORDS, 256, number of 16-bit words in the array. Power of two, ≥2.
- LATENCY, 3, cycles from request capture to mem_resp. Must be ≥1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mem_read  input  1  read request; held by the initiator until mem_resp.
- mem_write  input  1  write request; held by the initiator until mem_resp.
- mem_wmask  input  2  byte enables for writes (bit0 = low byte, bit1 = high byte).
- mem_address  input  16  byte address; bit0 is ignored for the word index.
- mem_wdata  input  16  write data.
- mem_rdata  output  16  read data; valid when mem_resp=1.
- mem_resp  output  1  one-cycle transaction-complete pulse.
- mem_err  output  1  qualifies mem_resp: out-of-range address or protocol error.

Behaviour:
- Reset (async, reset_n=0):
  - FSM goes to IDLE; latency counter cleared.
  - mem_resp=0, mem_err=0, mem_rdata=16'h0000.
  - Array contents are not reset and are retained across reset.
- Word index = mem_address[log2(DEPTH_WORDS):1]. Address is in range iff mem_address[15:1] < DEPTH_WORDS.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read|mem_write is high at a rising edge, capture read, write, wmask, address and wdata into holding registers.
  - Go to WAIT with count=LATENCY-1, or straight to RESP if LATENCY=1.
  - Otherwise stay in IDLE.
- WAIT: decrement count each cycle. At count==0 go to RESP.
- RESP:
  - mem_resp=1 for exactly one cycle, then IDLE.
  - The array operation commits on the edge entering RESP.
  - mem_rdata and mem_err are registered, so they are valid during the RESP cycle.
- Latency: a request first sampled at the end of cycle T gives mem_resp high during cycle T+LATENCY. Back-to-back requests therefore have a throughput of one per LATENCY+1 cycles.
- Input changes after capture (address, wdata, wmask, or dropped read/write) are ignored until the transaction completes.
- In the cycle after RESP the FSM is in IDLE. A still-asserted request there starts a new transaction (the initiator must deassert on mem_resp).
- Reads:
  - mem_rdata = full 16-bit word at the index; wmask is ignored.
  - mem_rdata holds its value until the next mem_resp.
- Writes:
  - Only the bytes enabled by wmask are updated.
  - wmask=2'b00 is a legal no-op write and still responds.
  - mem_rdata is unchanged on a write response.
- Out of range: mem_err=1 with mem_resp. Reads return 16'h0000; writes are dropped.
- mem_read and mem_write both high at capture: protocol error. mem_err=1, no array update, mem_rdata=16'h0000.
- mem_err is 0 whenever mem_resp is 0.
- Reset mid-transaction: the transaction is aborted with no mem_resp. A write whose commit edge has not occurred does not modify the array.

Test Plan:
- LATENCY=3: write 0xBEEF to 0x0010 with wmask=11 held from cycle 0 → mem_resp only in cycle 3, mem_err=0. Read 0x0010 → mem_rdata=0xBEEF with mem_resp.
- Byte writes: word 0x0020 =0x1234; write 0xAB55 wmask=01 then 0xCD00 wmask=10 → read returns 0xCD55. A write with wmask=00 leaves 0xCD55 unchanged.
- Odd address: write 0x5A5A to 0x0031, read 0x0030 → 0x5A5A (bit0 ignored).
- Out of range (DEPTH_WORDS=256): read 0x0200 → mem_resp=1, mem_err=1, mem_rdata=0x0000. A write to 0x0200 followed by reads of indices 0 and 255 shows no aliasing.
- Protocol error and capture:
  - Read and write both high → mem_err=1, array unchanged.
  - Address switched from 0x0010 to 0x0020 one cycle after capture → data from 0x0010 returned.
- Reset: reset_n low in the WAIT state of a write to 0x0040 (previously 0x1111) → mem_resp never pulses, outputs 0. After release, read 0x0040=0x1111, and LATENCY=1 gives mem_resp in the next cycle.
